l2_port_arbiter: RTL and testbench

L2_PORT_ARBITER -- requirements
Module: l2_port_arbiter

---
 rtl/mem_pkg.sv | 18 +
 rtl/rr_picker.sv | 35 +++
 rtl/l2_port_arbiter.sv | 178 +++++++++++++++++
 tb/tb_l2_port_arbiter.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the L2 port arbiter.
package mem_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_LINE_W = 256;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    // Width of a channel index; a single channel still gets one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_picker
    import mem_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = idx_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   grant,
    output logic               any
);

    int               idx;
    logic [IDX_W-1:0] sel;

    // Scan channels starting at ptr; the first requester found wins.
    always_comb begin
        grant = '0;
        any   = 1'b0;
        idx   = 0;
        sel   = '0;
        // NOTE: blocking assignments here so each loop iteration sees 'any' as updated by the previous one.
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            sel = IDX_W'(idx);
            if (!any && req[sel]) begin
                any   = 1'b1;
                grant = sel;
            end
        end
    end

endmodule

// File: rtl/l2_port_arbiter.sv
// Round-robin arbiter giving NUM_REQ requesters one-at-a-time access to an L2 port.
// Optional watchdog enabled by defining MEM_ARB_TIMEOUT_EN.
module l2_port_arbiter
    import mem_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ADDR_W         = DEFAULT_ADDR_W,
    parameter int LINE_W         = DEFAULT_LINE_W,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ-1:0]        req_write_en,
    input  logic [NUM_REQ*LINE_W-1:0] req_write_data,
    output logic [NUM_REQ-1:0]        resp_done,
    output logic [NUM_REQ-1:0]        resp_fault,
    output logic [LINE_W-1:0]         resp_data,
    output logic [idx_w(NUM_REQ)-1:0] grant_id,
    output logic [ADDR_W-1:0]         l2_addr,
    output logic                      l2_request,
    output logic                      l2_write_en,
    output logic [LINE_W-1:0]         l2_write_data,
    input  logic [LINE_W-1:0]         l2_data,
    input  logic                      l2_done
);

    localparam int IDX_W = idx_w(NUM_REQ);

    if (NUM_REQ < 1 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("l2_port_arbiter: NUM_REQ must be 1..8 and TIMEOUT_CYCLES >= 1");
    end

    arb_state_t          state_q, state_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    grant_id_q, grant_id_d;
    logic                l2_request_q, l2_request_d;
    logic                l2_write_en_q, l2_write_en_d;
    logic [ADDR_W-1:0]   l2_addr_q, l2_addr_d;
    logic [LINE_W-1:0]   l2_write_data_q, l2_write_data_d;
    logic [NUM_REQ-1:0]  resp_done_q, resp_done_d;
    logic [LINE_W-1:0]   resp_data_q, resp_data_d;

    logic [IDX_W-1:0]    pick_idx;
    logic                pick_any;
    logic [IDX_W-1:0]    next_ptr;
    logic [NUM_REQ-1:0]  grant_mask;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0]     wd_q, wd_d;
    logic [NUM_REQ-1:0]  resp_fault_q, resp_fault_d;
`endif

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_picker (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .grant (pick_idx),
        .any   (pick_any)
    );

    // Pointer after the current owner, wrapping; stays 0 with a single channel.
    assign next_ptr   = (int'(grant_id_q) == NUM_REQ - 1) ? '0 : grant_id_q + IDX_W'(1);
    assign grant_mask = NUM_REQ'(1) << grant_id_q;

    // Next-state and registered-output computation for the IDLE/BUSY/RESP sequence.
    always_comb begin
        // NOTE: every _d gets a default first so no path leaves it unassigned (no latches).
        state_d         = state_q;
        rr_ptr_d        = rr_ptr_q;
        grant_id_d      = grant_id_q;
        l2_request_d    = l2_request_q;
        l2_write_en_d   = l2_write_en_q;
        l2_addr_d       = l2_addr_q;
        l2_write_data_d = l2_write_data_q;
        resp_done_d     = '0;
        resp_data_d     = resp_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
        wd_d            = wd_q;
        resp_fault_d    = '0;
`endif
        unique case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d         = BUSY;
                    grant_id_d      = pick_idx;
                    l2_request_d    = 1'b1;
                    l2_write_en_d   = req_write_en[pick_idx];
                    l2_addr_d       = req_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
                    l2_write_data_d = req_write_data[int'(pick_idx)*LINE_W +: LINE_W];
`ifdef MEM_ARB_TIMEOUT_EN
                    wd_d            = '0;
`endif
                end
            end
            BUSY: begin
                if (l2_done) begin
                    state_d       = RESP;
                    l2_request_d  = 1'b0;
                    l2_write_en_d = 1'b0;
                    resp_done_d   = grant_mask;
                    resp_data_d   = l2_data;
                    rr_ptr_d      = next_ptr;
                end
`ifdef MEM_ARB_TIMEOUT_EN
                else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d       = RESP;
                    l2_request_d  = 1'b0;
                    l2_write_en_d = 1'b0;
                    resp_done_d   = grant_mask;
                    resp_fault_d  = grant_mask;
                    resp_data_d   = '0;
                    rr_ptr_d      = next_ptr;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
`endif
            end
            RESP: begin
                // Requests are not sampled here; the next grant happens from IDLE.
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop updates from pre-edge values.
        if (reset) begin
            state_q         <= IDLE;
            rr_ptr_q        <= '0;
            grant_id_q      <= '0;
            l2_request_q    <= 1'b0;
            l2_write_en_q   <= 1'b0;
            l2_addr_q       <= '0;
            l2_write_data_q <= '0;
            resp_done_q     <= '0;
            resp_data_q     <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_q            <= '0;
            resp_fault_q    <= '0;
`endif
        end else begin
            state_q         <= state_d;
            rr_ptr_q        <= rr_ptr_d;
            grant_id_q      <= grant_id_d;
            l2_request_q    <= l2_request_d;
            l2_write_en_q   <= l2_write_en_d;
            l2_addr_q       <= l2_addr_d;
            l2_write_data_q <= l2_write_data_d;
            resp_done_q     <= resp_done_d;
            resp_data_q     <= resp_data_d;
`ifdef MEM_ARB_TIMEOUT_EN
            wd_q            <= wd_d;
            resp_fault_q    <= resp_fault_d;
`endif
        end
    end

    assign resp_done     = resp_done_q;
    assign resp_data     = resp_data_q;
    assign grant_id      = grant_id_q;
    assign l2_addr       = l2_addr_q;
    assign l2_request    = l2_request_q;
    assign l2_write_en   = l2_write_en_q;
    assign l2_write_data = l2_write_data_q;
`ifdef MEM_ARB_TIMEOUT_EN
    assign resp_fault    = resp_fault_q;
`else
    assign resp_fault    = '0;
`endif

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Self-checking bench for l2_port_arbiter: transaction-level reference model,
// directed scenarios with literal expectations, then randomized traffic.
// The watchdog scenarios run when MEM_ARB_TIMEOUT_EN is defined.
module tb_l2_port_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int LW = 256;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid, req_write_en;
    logic [N*AW-1:0] req_addr;
    logic [N*LW-1:0] req_write_data;
    logic [N-1:0]    resp_done, resp_fault;
    logic [LW-1:0]   resp_data;
    logic [1:0]      grant_id;
    logic [AW-1:0]   l2_addr;
    logic            l2_request, l2_write_en;
    logic [LW-1:0]   l2_write_data, l2_data;
    logic            l2_done;

    l2_port_arbiter #(
        .NUM_REQ(N), .ADDR_W(AW), .LINE_W(LW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_addr(req_addr),
        .req_write_en(req_write_en), .req_write_data(req_write_data),
        .resp_done(resp_done), .resp_fault(resp_fault), .resp_data(resp_data),
        .grant_id(grant_id), .l2_addr(l2_addr), .l2_request(l2_request),
        .l2_write_en(l2_write_en), .l2_write_data(l2_write_data),
        .l2_data(l2_data), .l2_done(l2_done)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // ---------------- reference model (transaction level) ----------------
    int            m_owner = -1;   // channel currently holding L2, -1 if none
    int            m_last  = 0;    // channel whose response is being reported
    int            m_rr    = 0;    // channel with first priority next time
    int            m_busy  = 0;    // cycles the owner has spent waiting on L2
    int            m_gid   = 0;
    bit            m_pulse = 0;    // a response is visible this cycle
    bit            m_fault = 0;
    logic [LW-1:0] m_data  = '0;
    logic [AW-1:0] m_addr  = '0;
    logic          m_we    = 1'b0;
    logic [LW-1:0] m_wdata = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_owner = -1; m_rr = 0; m_busy = 0; m_gid = 0;
            m_pulse = 0; m_fault = 0; m_data = '0;
        end else if (m_pulse) begin
            m_pulse = 0; m_fault = 0;
        end else if (m_owner < 0) begin
            for (int k = 0; k < N; k++) begin
                if (req_valid[(m_rr + k) % N]) begin
                    m_owner = (m_rr + k) % N;
                    break;
                end
            end
            if (m_owner >= 0) begin
                m_gid   = m_owner;
                m_busy  = 0;
                m_addr  = req_addr[m_owner*AW +: AW];
                m_we    = req_write_en[m_owner];
                m_wdata = req_write_data[m_owner*LW +: LW];
            end
        end else begin
            m_busy++;
            if (l2_done) begin
                m_pulse = 1; m_fault = 0; m_data = l2_data;
                m_last = m_owner; m_rr = (m_owner + 1) % N; m_owner = -1;
            end
`ifdef MEM_ARB_TIMEOUT_EN
            else if (m_busy == TO) begin
                m_pulse = 1; m_fault = 1; m_data = '0;
                m_last = m_owner; m_rr = (m_owner + 1) % N; m_owner = -1;
            end
`endif
        end
    end

    task automatic compare_outputs();
        logic [N-1:0] exp_done;
        exp_done = m_pulse ? N'(1 << m_last) : '0;
        check("l2_request", l2_request, m_owner >= 0);
        if (m_owner >= 0) begin
            check("l2_addr", l2_addr, m_addr);
            check("l2_write_en", l2_write_en, m_we);
            check("l2_write_data", l2_write_data, m_wdata);
            check("grant_id", grant_id, m_gid);
        end
        check("resp_done", resp_done, exp_done);
        check("resp_fault", resp_fault, m_fault ? exp_done : '0);
        if (m_pulse) check("resp_data", resp_data, m_data);
    endtask

    // ---------------- requesters and L2 responder ----------------
    logic [N-1:0] rearm     = '0;   // channels to re-request after their response
    logic [N-1:0] hold_mask = '0;   // channels that request continuously
    int           l2_lat    = 1;    // BUSY cycle in which L2 answers; 0 = never
    int           l2_seen   = 0;
    bit           spurious  = 0;
    bit           rand_data = 0;
    int           cyc       = 0;

    task automatic tick();
        @(negedge clk);
        compare_outputs();
        req_valid = req_valid | rearm;
        rearm     = resp_done & hold_mask;
        req_valid = req_valid & ~resp_done;
        if (l2_request) begin
            l2_seen++;
            l2_done = (l2_seen == l2_lat);
        end else begin
            l2_seen = 0;
            l2_done = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
        end
        if (rand_data) l2_data = {8{$urandom()}};
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; req_valid = '0; rearm = '0; hold_mask = '0;
        tick(); tick();
        reset = 1'b0;
    endtask

    // Transaction observation results.
    int            t_hi, t_pulses, t_first, t_ptick;
    bit            t_done;
    logic [N-1:0]  t_pmask, t_pfault;
    logic [LW-1:0] t_pdata, cap_wdata;
    logic [AW-1:0] cap_addr;
    logic          cap_we;

    task automatic run_txn(input int budget, input bit withdraw);
        t_hi = 0; t_pulses = 0; t_first = -1; t_ptick = -1; t_done = 0;
        t_pmask = '0; t_pfault = '0; t_pdata = '0;
        for (int t = 1; t <= budget && !t_done; t++) begin
            tick();
            if (l2_request) begin
                if (t_hi == 0) begin
                    t_first = t; cap_we = l2_write_en; cap_addr = l2_addr; cap_wdata = l2_write_data;
                end
                t_hi++;
                if (withdraw && t_hi == 2) req_valid = '0;
            end
            if (resp_done != '0) begin
                t_pulses++; t_pmask = resp_done; t_pfault = resp_fault; t_pdata = resp_data; t_ptick = t;
            end else if (t_pulses > 0) begin
                t_done = 1;
            end
        end
        check("txn_completed", t_done, 1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int g_ids[$];
        int g_cyc[$];
        bit prev_req;

        req_addr = '0; req_write_en = '0; req_write_data = '0;
        l2_data = '0; l2_done = 1'b0;

        // Reset state.
        do_reset();
        check("rst_l2_request", l2_request, 1'b0);
        check("rst_grant_id", grant_id, 2'd0);
        check("rst_l2_addr", l2_addr, '0);
        check("rst_l2_write_data", l2_write_data, '0);
        check("rst_resp_done", resp_done, '0);
        check("rst_resp_data", resp_data, '0);
        check("rst_resp_fault", resp_fault, '0);

        // Single read on channel 2, L2 answers in its 5th cycle.
        req_addr[2*AW +: AW] = 32'h0000_1040;
        l2_lat = 5; l2_data = {32{8'hA5}};
        req_valid = 4'b0100;
        run_txn(40, 0);
        check("rd_first_request_latency", t_first, 1);
        check("rd_l2_request_cycles", t_hi, 5);
        check("rd_l2_addr", cap_addr, 32'h0000_1040);
        check("rd_resp_done_mask", t_pmask, 4'b0100);
        check("rd_resp_done_cycles", t_pulses, 1);
        check("rd_resp_tick", t_ptick, 6);
        check("rd_resp_data", t_pdata, {32{8'hA5}});

        // Write on channel 1.
        req_addr[1*AW +: AW] = 32'h0000_2000;
        req_write_en = 4'b0010;
        req_write_data[1*LW +: LW] = {8{32'hDEAD_BEEF}};
        l2_lat = 2;
        req_valid = 4'b0010;
        run_txn(40, 0);
        check("wr_l2_write_en", cap_we, 1'b1);
        check("wr_l2_addr", cap_addr, 32'h0000_2000);
        check("wr_l2_write_data", cap_wdata, {8{32'hDEAD_BEEF}});
        check("wr_resp_done_mask", t_pmask, 4'b0010);
        req_write_en = '0;

        // Fairness: every channel requesting continuously from reset, zero-wait L2.
        reset = 1'b1; req_valid = 4'hF; hold_mask = 4'hF; rearm = '0; l2_lat = 1;
        tick(); tick();
        reset = 1'b0;
        prev_req = 1'b0;
        for (int t = 0; t < 40 && g_ids.size() < 5; t++) begin
            tick();
            if (l2_request && !prev_req) begin
                g_ids.push_back(int'(grant_id));
                g_cyc.push_back(cyc);
            end
            prev_req = l2_request;
        end
        check("fair_grant_count", g_ids.size(), 5);
        if (g_ids.size() == 5) begin
            for (int i = 0; i < 5; i++) check("fair_grant_order", g_ids[i], i % 4);
            for (int i = 1; i < 5; i++) check("fair_grant_spacing", g_cyc[i] - g_cyc[i-1], 3);
        end
        hold_mask = '0; rearm = '0; req_valid = '0;
        for (int t = 0; t < 4; t++) tick();

        // Reset on the second BUSY cycle of a channel 0 request.
        do_reset();
        l2_lat = 0;
        req_valid = 4'b0001;
        for (int t = 0; t < 10 && !l2_request; t++) tick();
        check("rstbusy_granted", l2_request, 1'b1);
        tick();
        reset = 1'b1; req_valid = '0;
        tick();
        check("rstbusy_l2_request", l2_request, 1'b0);
        check("rstbusy_resp_done", resp_done, '0);
        reset = 1'b0;
        for (int t = 0; t < 3; t++) begin
            tick();
            check("rstbusy_no_resp", resp_done, '0);
        end

        // Withdrawal mid-BUSY on channel 0.
        req_addr[0 +: AW] = 32'h0000_0300;
        l2_lat = 4;
        req_valid = 4'b0001;
        run_txn(40, 1);
        check("wd_resp_done_mask", t_pmask, 4'b0001);
        check("wd_l2_request_cycles", t_hi, 4);

`ifdef MEM_ARB_TIMEOUT_EN
        // L2 never answers channel 3: fault after TO busy cycles.
        do_reset();
        l2_lat = 0; l2_data = {32{8'h5A}};
        req_valid = 4'b1000;
        run_txn(40, 0);
        check("to_l2_request_cycles", t_hi, TO);
        check("to_resp_done_mask", t_pmask, 4'b1000);
        check("to_resp_fault_mask", t_pfault, 4'b1000);
        check("to_resp_data", t_pdata, '0);
        l2_lat = 1;
        req_valid = 4'b1001;
        run_txn(40, 0);
        check("to_next_grant", t_pmask, 4'b0001);
        req_valid = '0;
        tick();
        // L2 answers exactly as the count expires: completion wins.
        l2_lat = TO;
        req_valid = 4'b0100;
        run_txn(40, 0);
        check("to_tie_done_mask", t_pmask, 4'b0100);
        check("to_tie_no_fault", t_pfault, 4'b0000);
        check("to_tie_data", t_pdata, {32{8'h5A}});
`endif

        // Randomized traffic with spurious l2_done and occasional resets.
        do_reset();
        spurious = 1; rand_data = 1;
        for (int t = 0; t < 3000; t++) begin
            tick();
            if (reset) begin
                reset = 1'b0;
            end else if ($urandom_range(0, 499) == 0) begin
                reset = 1'b1;
            end
            if (!l2_request) l2_lat = $urandom_range(1, 10);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && !resp_done[i] && $urandom_range(0, 3) == 0) begin
                    req_valid[i]             = 1'b1;
                    req_write_en[i]          = $urandom_range(0, 1) == 1;
                    req_addr[i*AW +: AW]     = $urandom();
                    req_write_data[i*LW +: LW] = {8{$urandom()}};
                end else if (req_valid[i] && $urandom_range(0, 39) == 0) begin
                    req_valid[i] = 1'b0;
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
